if_prefetch_stage: RTL and testbench

Parametrised instruction-fetch stage with a small prefetch buffer between instruction memory and decode.
- Owns the PC and issues one fetch per cycle to a synchronous instruction memory (1-cycle read latency).
- Queues returned {next_pc, instr} pairs in a DEPTH-entry FIFO and hands them to ID over valid/ready.
- Branch redirect flushes the buffer and drops the in-flight fetch; decode back-pressure replaces the fixed IF/ID freeze.

---
 rtl/if_prefetch_stage_if.sv | 30 +++
 rtl/if_prefetch_stage.sv | 92 +++++++++
 tb/tb_if_prefetch_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response plus the decode-side valid/ready stream.
interface if_prefetch_stage_if #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32,
   parameter int DEPTH   = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic               fetch_en;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_addr;
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               out_valid;
   logic               out_ready;
   logic [ADDR_W-1:0]  out_next_pc;
   logic [INSTR_W-1:0] out_instr;
   logic [CNT_W-1:0]   buf_count;

   modport master (
      input  fetch_en, redirect_valid, redirect_addr, imem_rdata, out_ready,
      output imem_req, imem_addr, out_valid, out_next_pc, out_instr, buf_count
   );

   modport slave (
      output fetch_en, redirect_valid, redirect_addr, imem_rdata, out_ready,
      input  imem_req, imem_addr, out_valid, out_next_pc, out_instr, buf_count
   );
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: PC, 1-cycle imem request tracking and a DEPTH-entry prefetch FIFO to decode.
// Optional IF_FETCH_BYPASS_EN presents a response straight to decode when the FIFO is empty.
module if_prefetch_stage #(
   parameter int                ADDR_W   = 32,
   parameter int                INSTR_W  = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(4)
) (
   input  logic clk,
   input  logic rst,
   if_prefetch_stage_if.master bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  tag;
   logic               inflight;
   logic [ADDR_W-1:0]  fifo_npc   [DEPTH];
   logic [INSTR_W-1:0] fifo_instr [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count;

   logic               fifo_valid;
   logic               pop;
   logic               push;
   logic [ADDR_W-1:0]  resp_npc;
   logic [CNT_W:0]     credit_used;

   assign fifo_valid = (count != '0);
   assign pop        = fifo_valid & bus.out_ready;
   assign resp_npc   = tag + PC_INC;

`ifdef IF_FETCH_BYPASS_EN
   logic bypass_valid;
   assign bypass_valid    = inflight & ~bus.redirect_valid & ~fifo_valid;
   assign bus.out_valid   = fifo_valid | bypass_valid;
   assign bus.out_next_pc = fifo_valid   ? fifo_npc[rd_ptr]   :
                            bypass_valid ? resp_npc           : '0;
   assign bus.out_instr   = fifo_valid   ? fifo_instr[rd_ptr] :
                            bypass_valid ? bus.imem_rdata     : '0;
   assign push = inflight & ~bus.redirect_valid & ~(bypass_valid & bus.out_ready);
`else
   assign bus.out_valid   = fifo_valid;
   assign bus.out_next_pc = fifo_valid ? fifo_npc[rd_ptr]   : '0;
   assign bus.out_instr   = fifo_valid ? fifo_instr[rd_ptr] : '0;
   assign push = inflight & ~bus.redirect_valid;
`endif

   // Slots already claimed: buffered entries minus the one leaving now, plus the response in flight.
   assign credit_used = {1'b0, count} - (CNT_W+1)'(pop) + (CNT_W+1)'(inflight);
   assign bus.imem_req = rst & bus.fetch_en & ~bus.redirect_valid &
                         (credit_used < (CNT_W+1)'(DEPTH));
   assign bus.imem_addr = pc;
   assign bus.buf_count = count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc       <= RESET_PC;
         tag      <= '0;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (bus.redirect_valid) begin
         pc       <= bus.redirect_addr;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= bus.imem_req;
         if (bus.imem_req) begin
            pc  <= pc + PC_INC;
            tag <= pc;
         end
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage needs no reset: outputs are gated by occupancy.
   always_ff @(posedge clk) begin
      if (rst && push) begin
         fifo_npc[wr_ptr]   <= resp_npc;
         fifo_instr[wr_ptr] <= bus.imem_rdata;
      end
   end
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: cycle table for fetch/backpressure/redirect plus reset and PC-wrap sequences.
module tb_if_prefetch_stage;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   if_prefetch_stage_if #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4)) bus ();
   if_prefetch_stage_if #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4)) bus5 ();

   if_prefetch_stage #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4),
                       .RESET_PC(32'h0), .PC_INC(32'd4)) dut (
      .clk(clk), .rst(rst), .bus(bus.master));

   if_prefetch_stage #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4),
                       .RESET_PC(32'hFFFF_FFF8), .PC_INC(32'd4)) dut5 (
      .clk(clk), .rst(rst), .bus(bus5.master));

   typedef struct {
      logic        fe;
      logic        redir;
      logic [31:0] raddr;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] npc;
      logic [31:0] instr;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vecs[23];

   function automatic vec_t mk(input logic fe, input logic redir, input logic [31:0] raddr,
                               input logic rdy, input logic req, input logic [31:0] addr,
                               input logic vld, input logic [31:0] npc, input logic [31:0] instr,
                               input logic [2:0] cnt);
      vec_t v;
      v.fe = fe; v.redir = redir; v.raddr = raddr; v.rdy = rdy;
      v.req = req; v.addr = addr; v.vld = vld; v.npc = npc; v.instr = instr; v.cnt = cnt;
      return v;
   endfunction

   // Memory contents: word n holds (n+1)*0x11.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ((a >> 2) + 32'd1) * 32'h11;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Advance one cycle; the memory model answers each request one cycle later.
   task automatic tick();
      logic        req_s, req5_s;
      logic [31:0] addr_s, addr5_s;
      req_s  = bus.imem_req;  addr_s  = bus.imem_addr;
      req5_s = bus5.imem_req; addr5_s = bus5.imem_addr;
      @(posedge clk);
      #1;
      bus.imem_rdata  = req_s  ? mem_word(addr_s)  : 32'hDEAD_BEEF;
      bus5.imem_rdata = req5_s ? mem_word(addr5_s) : 32'hDEAD_BEEF;
   endtask

   task automatic apply_check(input string tag, input vec_t v);
      bus.fetch_en       = v.fe;
      bus.redirect_valid = v.redir;
      bus.redirect_addr  = v.raddr;
      bus.out_ready      = v.rdy;
      @(negedge clk);
      check({tag, ".req"},   64'(bus.imem_req),    64'(v.req));
      check({tag, ".addr"},  64'(bus.imem_addr),   64'(v.addr));
      check({tag, ".valid"}, 64'(bus.out_valid),   64'(v.vld));
      check({tag, ".npc"},   64'(bus.out_next_pc), 64'(v.npc));
      check({tag, ".instr"}, 64'(bus.out_instr),   64'(v.instr));
      check({tag, ".count"}, 64'(bus.buf_count),   64'(v.cnt));
      tick();
   endtask

   task automatic check5(input string tag, input logic [31:0] addr, input logic vld,
                         input logic [31:0] npc, input logic [31:0] instr);
      @(negedge clk);
      check({tag, ".addr"},  64'(bus5.imem_addr),   64'(addr));
      check({tag, ".valid"}, 64'(bus5.out_valid),   64'(vld));
      check({tag, ".npc"},   64'(bus5.out_next_pc), 64'(npc));
      check({tag, ".instr"}, 64'(bus5.out_instr),   64'(instr));
      tick();
   endtask

   initial begin
      // fe redir raddr rdy | req addr vld npc instr cnt
      vecs[0]  = mk(1, 0, 0, 1,  1, 32'h000, 0, 32'h000, 32'h000, 0);
      vecs[1]  = mk(1, 0, 0, 1,  1, 32'h004, 0, 32'h000, 32'h000, 0);
      vecs[2]  = mk(1, 0, 0, 1,  1, 32'h008, 1, 32'h004, 32'h011, 1);
      vecs[3]  = mk(1, 0, 0, 1,  1, 32'h00C, 1, 32'h008, 32'h022, 1);
      vecs[4]  = mk(1, 0, 0, 1,  1, 32'h010, 1, 32'h00C, 32'h033, 1);
      vecs[5]  = mk(1, 0, 0, 0,  1, 32'h014, 1, 32'h010, 32'h044, 1);
      vecs[6]  = mk(1, 0, 0, 0,  1, 32'h018, 1, 32'h010, 32'h044, 2);
      vecs[7]  = mk(1, 0, 0, 0,  0, 32'h01C, 1, 32'h010, 32'h044, 3);
      vecs[8]  = mk(1, 0, 0, 0,  0, 32'h01C, 1, 32'h010, 32'h044, 4);
      vecs[9]  = mk(1, 0, 0, 0,  0, 32'h01C, 1, 32'h010, 32'h044, 4);
      vecs[10] = mk(1, 0, 0, 1,  1, 32'h01C, 1, 32'h010, 32'h044, 4);
      vecs[11] = mk(1, 0, 0, 1,  1, 32'h020, 1, 32'h014, 32'h055, 3);
      vecs[12] = mk(1, 1, 32'h100, 0,  0, 32'h024, 1, 32'h018, 32'h066, 3);
      vecs[13] = mk(1, 0, 0, 1,  1, 32'h100, 0, 32'h000, 32'h000, 0);
      vecs[14] = mk(1, 0, 0, 1,  1, 32'h104, 0, 32'h000, 32'h000, 0);
      vecs[15] = mk(1, 0, 0, 1,  1, 32'h108, 1, 32'h104, 32'h451, 1);
      vecs[16] = mk(1, 0, 0, 1,  1, 32'h10C, 1, 32'h108, 32'h462, 1);
      vecs[17] = mk(1, 1, 32'h200, 1,  0, 32'h110, 1, 32'h10C, 32'h473, 1);
      vecs[18] = mk(1, 0, 0, 1,  1, 32'h200, 0, 32'h000, 32'h000, 0);
      vecs[19] = mk(1, 0, 0, 1,  1, 32'h204, 0, 32'h000, 32'h000, 0);
      vecs[20] = mk(1, 0, 0, 1,  1, 32'h208, 1, 32'h204, 32'h891, 1);
      vecs[21] = mk(0, 0, 0, 0,  0, 32'h20C, 1, 32'h208, 32'h8A2, 1);
      vecs[22] = mk(0, 0, 0, 0,  0, 32'h20C, 1, 32'h208, 32'h8A2, 2);

      bus.fetch_en = 1'b0;  bus.redirect_valid = 1'b0;  bus.redirect_addr = '0;
      bus.out_ready = 1'b0; bus.imem_rdata = 32'hDEAD_BEEF;
      bus5.fetch_en = 1'b0; bus5.redirect_valid = 1'b0; bus5.redirect_addr = '0;
      bus5.out_ready = 1'b0; bus5.imem_rdata = 32'hDEAD_BEEF;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset.req",   64'(bus.imem_req),    64'(0));
      check("reset.addr",  64'(bus.imem_addr),   64'(0));
      check("reset.valid", 64'(bus.out_valid),   64'(0));
      check("reset.npc",   64'(bus.out_next_pc), 64'(0));
      check("reset.instr", 64'(bus.out_instr),   64'(0));
      check("reset.count", 64'(bus.buf_count),   64'(0));
      @(posedge clk);
      #1;
      rst = 1'b1;

      for (int i = 0; i < 23; i++)
         apply_check($sformatf("vec%0d", i), vecs[i]);

      // Reset mid-stream with two entries buffered and a fetch in flight.
      apply_check("pre_rst", mk(1, 0, 0, 0,  1, 32'h20C, 1, 32'h208, 32'h8A2, 2));
      rst = 1'b0;
      #1;
      check("async_rst.valid", 64'(bus.out_valid),   64'(0));
      check("async_rst.count", 64'(bus.buf_count),   64'(0));
      check("async_rst.npc",   64'(bus.out_next_pc), 64'(0));
      check("async_rst.instr", 64'(bus.out_instr),   64'(0));
      check("async_rst.req",   64'(bus.imem_req),    64'(0));
      check("async_rst.addr",  64'(bus.imem_addr),   64'(0));
      tick();
      rst = 1'b1;
      apply_check("post_rst0", mk(1, 0, 0, 1,  1, 32'h000, 0, 32'h000, 32'h000, 0));
      apply_check("post_rst1", mk(1, 0, 0, 1,  1, 32'h004, 0, 32'h000, 32'h000, 0));
      apply_check("post_rst2", mk(1, 0, 0, 1,  1, 32'h008, 1, 32'h004, 32'h011, 1));

      // PC wrap from RESET_PC near the top of the address space.
      bus5.fetch_en  = 1'b1;
      bus5.out_ready = 1'b1;
      check5("wrap0", 32'hFFFF_FFF8, 0, 32'h0000_0000, 32'h0000_0000);
      check5("wrap1", 32'hFFFF_FFFC, 0, 32'h0000_0000, 32'h0000_0000);
      check5("wrap2", 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h3FFF_FFEF);
      check5("wrap3", 32'h0000_0004, 1, 32'h0000_0000, 32'h4000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
